// File: rtl/spi_cmd_pkg.sv
// Shared types for the SPI nibble-to-command assembler: FSM states, opcode names, nibble width.
package spi_cmd_pkg;

   localparam int NIB_W = 4;

   typedef enum logic [1:0] {IDLE, GOT_OP, GOT_A, HOLD} asm_state_t;

   typedef enum logic [2:0] {ADD, SUB, AND, OR, XOR, SHL, SHR, PASS} opcode_t;

endpackage

// File: rtl/frame_timeout_counter.sv
// Saturating inter-nibble gap counter; expired is asserted while running at count TIMEOUT_CYCLES-1.
// Latency: the count updates one cycle after run/clr. There is no backpressure; clr has priority over run.
module frame_timeout_counter #(
   parameter int TIMEOUT_CYCLES = 50_000_000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic run,
   input  logic clr,
   output logic expired
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_count <= '0;
      end else if (clr) begin
         r_count <= '0;
      end else if (run && (r_count != LAST)) begin
         r_count <= r_count + CNT_W'(1);
      end
   end

   assign expired = run && (r_count == LAST);

endmodule

// File: rtl/spi_cmd_assembler.sv
// Gathers opcode/A/B nibbles into one command and presents it on a valid/ready handshake with sticky error flags.
// Latency: cmd_valid rises one cycle after the third nibble. A nibble that arrives while a command is held without transfer is dropped.
module spi_cmd_assembler
   import spi_cmd_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 50_000_000
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [NIB_W-1:0] nib_data_in,
   input  logic             nib_valid_in,
   output logic [2:0]       cmd_opcode,
   output logic [NIB_W-1:0] cmd_a,
   output logic [NIB_W-1:0] cmd_b,
   output logic             cmd_valid,
   input  logic             cmd_ready,
   output logic             busy,
   output logic             err_overrun,
   output logic             err_timeout,
   output logic             err_badop,
   input  logic             err_clr
);

   asm_state_t       r_state;
   asm_state_t       w_state_nxt;
   opcode_t          r_op;
   logic [NIB_W-1:0] r_a;
   logic [NIB_W-1:0] r_b;
   logic             r_ovr;
   logic             r_to;
   logic             r_bad;

   logic w_xfer;
   logic w_open;
   logic w_run;
   logic w_expired;
   logic w_nib_acc;
   logic w_ld_op;
   logic w_ld_a;
   logic w_ld_b;
   logic w_set_ovr;
   logic w_set_to;
   logic w_set_bad;

   assign w_xfer = (r_state == HOLD) && cmd_ready;
   // A transfer frees the slot in the same cycle, so a nibble then is a fresh opcode.
   assign w_open = (r_state == IDLE) || w_xfer;
   assign w_run  = (r_state == GOT_OP) || (r_state == GOT_A);

   always_comb begin
      w_state_nxt = r_state;
      w_nib_acc   = 1'b0;
      w_ld_op     = 1'b0;
      w_ld_a      = 1'b0;
      w_ld_b      = 1'b0;
      w_set_ovr   = 1'b0;
      w_set_to    = 1'b0;
      w_set_bad   = 1'b0;
      if (w_open) begin
         w_state_nxt = IDLE;
         if (nib_valid_in) begin
            if (nib_data_in[NIB_W-1]) begin
               w_set_bad = 1'b1;
            end else begin
               w_ld_op     = 1'b1;
               w_nib_acc   = 1'b1;
               w_state_nxt = GOT_OP;
            end
         end
      end else begin
         case (r_state)
            GOT_OP: begin
               if (nib_valid_in) begin
                  w_ld_a      = 1'b1;
                  w_nib_acc   = 1'b1;
                  w_state_nxt = GOT_A;
               end else if (w_expired) begin
                  w_set_to    = 1'b1;
                  w_state_nxt = IDLE;
               end
            end
            GOT_A: begin
               if (nib_valid_in) begin
                  w_ld_b      = 1'b1;
                  w_nib_acc   = 1'b1;
                  w_state_nxt = HOLD;
               end else if (w_expired) begin
                  w_set_to    = 1'b1;
                  w_state_nxt = IDLE;
               end
            end
            HOLD: begin
               w_set_ovr = nib_valid_in;
            end
            default: begin
               w_state_nxt = IDLE;
            end
         endcase
      end
   end

   frame_timeout_counter #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk     (clk),
      .reset_n (reset_n),
      .run     (w_run),
      .clr     (w_nib_acc || !w_run),
      .expired (w_expired)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_op  <= ADD;
         r_a   <= '0;
         r_b   <= '0;
         r_ovr <= 1'b0;
         r_to  <= 1'b0;
         r_bad <= 1'b0;
      end else begin
         if (w_ld_op) r_op <= opcode_t'(nib_data_in[2:0]);
         if (w_ld_a)  r_a  <= nib_data_in;
         if (w_ld_b)  r_b  <= nib_data_in;
         r_ovr <= w_set_ovr || (r_ovr && !err_clr);
         r_to  <= w_set_to  || (r_to  && !err_clr);
         r_bad <= w_set_bad || (r_bad && !err_clr);
      end
   end

   assign cmd_opcode  = r_op;
   assign cmd_a       = r_a;
   assign cmd_b       = r_b;
   assign cmd_valid   = (r_state == HOLD);
   assign busy        = w_run;
   assign err_overrun = r_ovr;
   assign err_timeout = r_to;
   assign err_badop   = r_bad;

endmodule

// File: tb/tb_spi_cmd_assembler.sv
// Bench for spi_cmd_assembler: directed vector table, timeout/overrun sequences, randomized run against a command-level model.
module tb_spi_cmd_assembler;

   localparam int T = 16;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [3:0] nib_data_in = 4'h0;
   logic       nib_valid_in = 1'b0;
   logic       cmd_ready = 1'b0;
   logic       err_clr = 1'b0;
   logic [2:0] cmd_opcode;
   logic [3:0] cmd_a;
   logic [3:0] cmd_b;
   logic       cmd_valid;
   logic       busy;
   logic       err_overrun;
   logic       err_timeout;
   logic       err_badop;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   spi_cmd_assembler #(.TIMEOUT_CYCLES(T)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .nib_data_in  (nib_data_in),
      .nib_valid_in (nib_valid_in),
      .cmd_opcode   (cmd_opcode),
      .cmd_a        (cmd_a),
      .cmd_b        (cmd_b),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .busy         (busy),
      .err_overrun  (err_overrun),
      .err_timeout  (err_timeout),
      .err_badop    (err_badop),
      .err_clr      (err_clr)
   );

   // Reference model: a list of nibbles gathered so far, a held command, and a silence count.
   bit         m_held;
   int         m_plen;
   int         m_sil;
   logic [2:0] m_op;
   logic [3:0] m_a;
   logic [3:0] m_b;
   bit         m_ovr, m_to, m_bad;

   function automatic logic [15:0] mk(input int v, input int b, input int op, input int a,
                                      input int bb, input int o, input int t, input int d);
      return {v[0], b[0], op[2:0], a[3:0], bb[3:0], o[0], t[0], d[0]};
   endfunction

   function automatic logic [15:0] dut_out();
      return {cmd_valid, busy, cmd_opcode, cmd_a, cmd_b, err_overrun, err_timeout, err_badop};
   endfunction

   function automatic logic [15:0] model_out();
      return {m_held, (m_plen != 0), m_op, m_a, m_b, m_ovr, m_to, m_bad};
   endfunction

   task automatic model_step(input bit rst_n, input bit nv, input logic [3:0] nib,
                             input bit rdy, input bit clr);
      bit s_ovr, s_to, s_bad;
      s_ovr = 1'b0; s_to = 1'b0; s_bad = 1'b0;
      if (!rst_n) begin
         m_held = 0; m_plen = 0; m_sil = 0;
         m_op = '0; m_a = '0; m_b = '0;
         m_ovr = 0; m_to = 0; m_bad = 0;
         return;
      end
      if (m_held && !rdy) begin
         s_ovr = nv;
      end else begin
         m_held = 0;
         if (m_plen == 0) begin
            if (nv) begin
               if (nib[3]) s_bad = 1'b1;
               else begin
                  m_op = nib[2:0]; m_plen = 1; m_sil = 0;
               end
            end
         end else if (nv) begin
            if (m_plen == 1) m_a = nib;
            else m_b = nib;
            m_plen++;
            m_sil = 0;
            if (m_plen == 3) begin
               m_held = 1; m_plen = 0;
            end
         end else begin
            m_sil++;
            if (m_sil == T) begin
               m_plen = 0; m_sil = 0; s_to = 1'b1;
            end
         end
      end
      m_ovr = s_ovr || (m_ovr && !clr);
      m_to  = s_to  || (m_to  && !clr);
      m_bad = s_bad || (m_bad && !clr);
   endtask

   task automatic tick(input bit rst_n, input bit nv, input int nib, input bit rdy, input bit clr);
      reset_n      = rst_n;
      nib_valid_in = nv;
      nib_data_in  = nib[3:0];
      cmd_ready    = rdy;
      err_clr      = clr;
      @(posedge clk);
      model_step(rst_n, nv, nib[3:0], rdy, clr);
      #1;
   endtask

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual {v,busy,op,a,b,ovr,to,bad}=%b_%b_%h_%h_%h_%b%b%b required %b_%b_%h_%h_%h_%b%b%b",
                  name, act[15], act[14], act[13:11], act[10:7], act[6:3], act[2], act[1], act[0],
                  exp[15], exp[14], exp[13:11], exp[10:7], exp[6:3], exp[2], exp[1], exp[0]);
      end
   endtask

   typedef struct {
      bit          rst_n;
      bit          nv;
      int          nib;
      bit          rdy;
      bit          clr;
      logic [15:0] exp;
   } vec_t;

   vec_t tbl[22];

   initial begin
      tbl[0]  = '{0, 0, 0,  0, 0, mk(0,0,0,0,0,  0,0,0)};
      tbl[1]  = '{1, 1, 2,  1, 0, mk(0,1,2,0,0,  0,0,0)};
      tbl[2]  = '{1, 1, 5,  1, 0, mk(0,1,2,5,0,  0,0,0)};
      tbl[3]  = '{1, 1, 10, 1, 0, mk(1,0,2,5,10, 0,0,0)};
      tbl[4]  = '{1, 0, 0,  1, 0, mk(0,0,2,5,10, 0,0,0)};
      tbl[5]  = '{1, 0, 0,  0, 0, mk(0,0,2,5,10, 0,0,0)};
      tbl[6]  = '{1, 1, 9,  0, 0, mk(0,0,2,5,10, 0,0,1)};
      tbl[7]  = '{1, 1, 15, 0, 1, mk(0,0,2,5,10, 0,0,1)};
      tbl[8]  = '{1, 0, 0,  0, 1, mk(0,0,2,5,10, 0,0,0)};
      tbl[9]  = '{1, 0, 0,  0, 0, mk(0,0,2,5,10, 0,0,0)};
      tbl[10] = '{1, 1, 1,  0, 0, mk(0,1,1,5,10, 0,0,0)};
      tbl[11] = '{1, 1, 7,  0, 0, mk(0,1,1,7,10, 0,0,0)};
      tbl[12] = '{1, 1, 3,  0, 0, mk(1,0,1,7,3,  0,0,0)};
      tbl[13] = '{1, 0, 0,  0, 0, mk(1,0,1,7,3,  0,0,0)};
      tbl[14] = '{1, 1, 4,  1, 0, mk(0,1,4,7,3,  0,0,0)};
      tbl[15] = '{1, 1, 6,  0, 0, mk(0,1,4,6,3,  0,0,0)};
      tbl[16] = '{1, 1, 8,  0, 0, mk(1,0,4,6,8,  0,0,0)};
      tbl[17] = '{0, 0, 0,  1, 0, mk(0,0,0,0,0,  0,0,0)};
      tbl[18] = '{1, 1, 1,  0, 0, mk(0,1,1,0,0,  0,0,0)};
      tbl[19] = '{1, 1, 2,  0, 0, mk(0,1,1,2,0,  0,0,0)};
      tbl[20] = '{0, 0, 0,  0, 0, mk(0,0,0,0,0,  0,0,0)};
      tbl[21] = '{1, 0, 0,  1, 0, mk(0,0,0,0,0,  0,0,0)};

      #1;
      for (int i = 0; i < 22; i++) begin
         tick(tbl[i].rst_n, tbl[i].nv, tbl[i].nib, tbl[i].rdy, tbl[i].clr);
         check($sformatf("tbl[%0d]", i), dut_out(), tbl[i].exp);
      end

      // Overrun: command held for 10 cycles, stray nibble dropped on the third.
      tick(1, 1, 2, 0, 0);
      tick(1, 1, 5, 0, 0);
      tick(1, 1, 10, 0, 0);
      check("hold_enter", dut_out(), mk(1,0,2,5,10,0,0,0));
      for (int c = 0; c < 10; c++) begin
         tick(1, (c == 2), 1, 0, 0);
         check($sformatf("hold_stable[%0d]", c), dut_out(), mk(1,0,2,5,10,(c >= 2),0,0));
      end
      tick(1, 0, 0, 1, 0);
      check("hold_release", dut_out(), mk(0,0,2,5,10,1,0,0));
      tick(1, 1, 3, 1, 0);
      tick(1, 1, 4, 1, 0);
      tick(1, 1, 5, 1, 0);
      check("after_ovr_cmd", dut_out(), mk(1,0,3,4,5,1,0,0));
      tick(1, 0, 0, 1, 1);
      check("ovr_clear", dut_out(), mk(0,0,3,4,5,0,0,0));

      // Timeout after exactly T silent cycles in GOT_OP.
      tick(1, 1, 3, 1, 0);
      for (int k = 1; k <= T; k++) begin
         tick(1, 0, 0, 1, 0);
         check($sformatf("to_wait[%0d]", k), dut_out(),
               (k < T) ? mk(0,1,3,4,5,0,0,0) : mk(0,0,3,4,5,0,1,0));
      end
      tick(1, 1, 1, 1, 0);
      tick(1, 1, 2, 1, 0);
      tick(1, 1, 3, 1, 0);
      check("after_to_cmd", dut_out(), mk(1,0,1,2,3,0,1,0));
      tick(1, 0, 0, 1, 1);
      check("after_to_xfer", dut_out(), mk(0,0,1,2,3,0,0,0));

      // Nibble on the expiring cycle wins; then GOT_A times out after T more.
      tick(1, 1, 6, 1, 0);
      for (int k = 1; k < T; k++) tick(1, 0, 0, 1, 0);
      check("edge_before", dut_out(), mk(0,1,6,2,3,0,0,0));
      tick(1, 1, 7, 1, 0);
      check("edge_nib_wins", dut_out(), mk(0,1,6,7,3,0,0,0));
      for (int k = 1; k <= T; k++) begin
         tick(1, 0, 0, 1, 0);
         check($sformatf("gota_to[%0d]", k), dut_out(),
               (k < T) ? mk(0,1,6,7,3,0,0,0) : mk(0,0,6,7,3,0,1,0));
      end

      // Randomized traffic; bursts alternate with sparse periods to provoke timeouts.
      tick(0, 0, 0, 0, 0);
      check("rand_reset", dut_out(), model_out());
      for (int i = 0; i < 4000; i++) begin
         int unsigned rate;
         bit nv, rdy, clr, rst_n;
         int nib;
         rate  = ((i / 400) % 2 == 1) ? 3 : 45;
         nv    = ($urandom_range(99) < rate);
         nib   = int'($urandom_range(15));
         rdy   = ($urandom_range(99) < 50);
         clr   = ($urandom_range(99) < 4);
         rst_n = !($urandom_range(999) < 3);
         tick(rst_n, nv, nib, rdy, clr);
         check($sformatf("rand[%0d]", i), dut_out(), model_out());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
